adc_scan_sched: RTL
===================

Name: adc_scan_sched

Overview:
Scan scheduler and serial engine for the 8-channel, 12-bit SPI ADC (ADC128S022-class) on the IMU board. It round-robins over a programmable channel mask and interleaves one-shot conversion requests from a second client at priority. It drives CS_n/SCLK/DIN, captures DOUT, and re-associates each result with its channel across the ADC's one-frame address pipeline.

Parameters:
CLK_DIV, 2, iCLK cycles per SCLK half-period (>=1)
NUM_CH, 8, ADC channel count (fixed 8; channel index 3 bits)

Ports:
iCLK  in  1  system clock
iRST_n  in  1  asynchronous active-low reset
iEN  in  1  scan enable
iCH_MASK  in  8  channels included in scan, bit n = channel n
iREQ  in  1  one-shot request, held until oREQ_ACK
iREQ_CH  in  3  requested channel, valid with iREQ
oREQ_ACK  out  1  one-cycle pulse: request latched
oREQ_DONE  out  1  one-cycle pulse: request result valid
oREQ_DATA  out  12  request result, held until next oREQ_DONE
oSMP_VALID  out  1  one-cycle pulse: any sample valid
oSMP_CH  out  3  channel of sample
oSMP_DATA  out  12  sample value, held until next oSMP_VALID
oBUSY  out  1  frame in progress
oCS_n  out  1  ADC chip select
oSCLK  out  1  ADC serial clock, idle high
oDIN  out  1  ADC control bit
iDOUT  in  1  ADC data bit

Behaviour:
- Reset (async, any time incl. mid-frame): oCS_n=1, oSCLK=1, oDIN=0, all pulses 0, data/ch regs 0, oBUSY=0, pending invalid, request slot empty, scan pointer=7 (first scan pick is ch0).
- Frame FSM: IDLE -> SETUP (CS_n=0, CLK_DIV cycles) -> 16 x {LO (SCLK=0, CLK_DIV cycles), HI (SCLK=1, CLK_DIV cycles)} -> HOLD (CLK_DIV cycles) -> GAP (CS_n=1, CLK_DIV cycles) -> IDLE. Frame = 35*CLK_DIV cycles; oBUSY=1 outside IDLE.
- Bit k (0..15): oDIN changes on entry to LO; iDOUT sampled on last cycle of HI. oDIN = addr[2],addr[1],addr[0] at k=2,3,4, else 0. Data D11..D0 captured at k=4..15, MSB first.
- Frame decision in IDLE (same cycle the frame starts): request slot full -> addr=REQ_CH, tag=request; else iEN=1 and iCH_MASK!=0 -> addr = next set mask bit after scan pointer (modulo 8), pointer updated, tag=scan; else pending valid with tag=request -> dummy frame addr=pending ch; else stay IDLE.
- Pipeline: result of frame N belongs to channel addressed in frame N-1 (pending). Pending invalid after reset or after an IDLE period -> result discarded. At HOLD entry: if pending valid, oSMP_VALID pulse with oSMP_CH/oSMP_DATA; if pending tag=request, oREQ_DONE pulse same cycle with oREQ_DATA. Then pending <= this frame's addr/tag.
- IDLE with no frame started invalidates pending (scan results for a dropped frame are lost; request results never lost due to dummy frame rule).
- Request handshake: slot empty and iREQ=1 -> latch iREQ_CH, oREQ_ACK pulse next cycle. Slot full (latched, or addressed but not done) -> no ACK; iREQ ignored. Slot frees on oREQ_DONE. Request frames do not move scan pointer.
- iEN/iCH_MASK changes sampled only at frame decision; in-progress frame always completes.
- Simultaneous iREQ and frame decision in same cycle: request not yet latched; served at next decision.

Decomposition:
- Package adc_sched_pkg: ADC_BITS=12, FRAME_BITS=16, ADDR_FIRST_BIT=2, DATA_FIRST_BIT=4, FSM state enum, tag enum {SCAN, REQ}.
- Sub-module adc_spi_frame: one frame (SETUP..GAP, divider, shift); iSTART/iADDR in, oDONE/oDATA out. Scheduler, pointer, pending, request slot in top.

Test Plan:
- Reset mid-frame at k=7 -> CS_n=1, SCLK=1 same cycle; all outputs 0; next frame result discarded.
- CLK_DIV=2, iEN=1, mask 8'h05, model returns 12'hA00+ch -> SCLK period 4 cycles, 16 pulses/frame, frame 70 cycles; samples ch0=A00, ch2=A02, ch0=A00...; first frame no oSMP_VALID.
- Scanning mask 8'h05, iREQ ch5 -> ACK 1 cycle; next frame addr 5; following frame oREQ_DONE+oSMP_VALID ch5 data A05; scan resumes with ch after last scanned.
- iEN=0, iREQ ch3 from IDLE -> two frames (addr 3 twice); oREQ_DONE data A03 after 2nd; then IDLE, oBUSY=0.
- iEN=1, mask 0 -> stays IDLE, CS_n=1, no pulses; set mask 8'h80 -> only ch7 addressed.
- Second iREQ while slot full -> no ACK until after oREQ_DONE, then ACK within 1 cycle.

Source files
------------

// File: rtl/adc_sched_pkg.sv
`default_nettype none
// ============================================================================
// adc_sched_pkg : shared constants, state/tag types and helpers for the ADC scan scheduler
// Rev 1.0
// ============================================================================
package adc_sched_pkg;

    localparam int ADC_BITS       = 12;
    localparam int FRAME_BITS     = 16;
    localparam int ADDR_FIRST_BIT = 2;
    localparam int DATA_FIRST_BIT = 4;
    localparam int CH_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } frame_state_t;

    typedef enum logic {
        TAG_SCAN = 1'b0,
        TAG_REQ  = 1'b1
    } tag_t;

    // Control word bit for frame bit k: channel address MSB first, zeros elsewhere.
    function automatic logic din_for_bit(input logic [CH_W-1:0] addr, input logic [3:0] k);
        logic d;
        d = 1'b0;
        if (k == 4'(ADDR_FIRST_BIT))
            d = addr[2];
        else if (k == 4'(ADDR_FIRST_BIT + 1))
            d = addr[1];
        else if (k == 4'(ADDR_FIRST_BIT + 2))
            d = addr[0];
        return d;
    endfunction

    // First set mask bit strictly after ptr, wrapping; returns ptr itself if only it is set.
    function automatic logic [CH_W-1:0] next_scan_ch(input logic [7:0] mask, input logic [CH_W-1:0] ptr);
        logic [CH_W-1:0] idx;
        logic [CH_W-1:0] res;
        logic            found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_frame.sv
`default_nettype none
// ============================================================================
// adc_spi_frame : one 16-bit ADC SPI frame (CS_n/SCLK/DIN drive, DOUT capture)
// Rev 1.0
// ============================================================================
module adc_spi_frame
    import adc_sched_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iSTART,
    input  logic [CH_W-1:0]     iADDR,
    input  logic                iDOUT,
    output logic                oDONE,
    output logic [ADC_BITS-1:0] oDATA,
    output logic                oBUSY,
    output logic                oCS_n,
    output logic                oSCLK,
    output logic                oDIN
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    frame_state_t          state_q;
    logic [DIV_W-1:0]      div_q;
    logic [3:0]            bit_q;
    logic [CH_W-1:0]       addr_q;
    logic [ADC_BITS-2:0]   shift_q;
    logic                  cs_n_q;
    logic                  sclk_q;
    logic                  din_q;
    logic                  busy_q;

    logic w_last;
    logic w_last_bit;
    logic w_data_bit;

    assign w_last     = (div_q == DIV_W'(CLK_DIV - 1));
    assign w_last_bit = (bit_q == 4'(FRAME_BITS - 1));
    assign w_data_bit = (bit_q >= 4'(DATA_FIRST_BIT));

    // Completion strobe is the final HI cycle so the caller can register it on HOLD entry.
    assign oDONE = (state_q == ST_HI) && w_last && w_last_bit;
    assign oDATA = {shift_q, iDOUT};
    assign oBUSY = busy_q;
    assign oCS_n = cs_n_q;
    assign oSCLK = sclk_q;
    assign oDIN  = din_q;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iSTART) begin
                        state_q <= ST_SETUP;
                        addr_q  <= iADDR;
                        div_q   <= '0;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (w_last) begin
                        state_q <= ST_LO;
                        div_q   <= '0;
                        bit_q   <= '0;
                        sclk_q  <= 1'b0;
                        din_q   <= din_for_bit(addr_q, 4'd0);
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_LO: begin
                    if (w_last) begin
                        state_q <= ST_HI;
                        div_q   <= '0;
                        sclk_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_HI: begin
                    if (w_last) begin
                        div_q <= '0;
                        if (w_data_bit)
                            shift_q <= {shift_q[ADC_BITS-3:0], iDOUT};
                        if (w_last_bit) begin
                            state_q <= ST_HOLD;
                            din_q   <= 1'b0;
                        end else begin
                            state_q <= ST_LO;
                            bit_q   <= bit_q + 4'd1;
                            sclk_q  <= 1'b0;
                            din_q   <= din_for_bit(addr_q, bit_q + 4'd1);
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_last) begin
                        state_q <= ST_GAP;
                        div_q   <= '0;
                        cs_n_q  <= 1'b1;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_last) begin
                        state_q <= ST_IDLE;
                        div_q   <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sched.sv
`default_nettype none
// ============================================================================
// adc_scan_sched : round-robin ADC scan with priority one-shot requests and result re-association
// Rev 1.0
// ============================================================================
module adc_scan_sched
    import adc_sched_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int NUM_CH  = 8
) (
    input  logic                iCLK,
    input  logic                iRST_n,
    input  logic                iEN,
    input  logic [NUM_CH-1:0]   iCH_MASK,
    input  logic                iREQ,
    input  logic [CH_W-1:0]     iREQ_CH,
    output logic                oREQ_ACK,
    output logic                oREQ_DONE,
    output logic [ADC_BITS-1:0] oREQ_DATA,
    output logic                oSMP_VALID,
    output logic [CH_W-1:0]     oSMP_CH,
    output logic [ADC_BITS-1:0] oSMP_DATA,
    output logic                oBUSY,
    output logic                oCS_n,
    output logic                oSCLK,
    output logic                oDIN,
    input  logic                iDOUT
);

    logic                w_busy;
    logic                w_frm_done;
    logic [ADC_BITS-1:0] w_frm_data;
    logic [CH_W-1:0]     w_scan_ch;
    logic                w_req_done;

    logic                start_d;
    logic [CH_W-1:0]     addr_d;
    tag_t                tag_d;
    logic [CH_W-1:0]     ptr_d;

    logic [CH_W-1:0]     ptr_q;
    logic [CH_W-1:0]     cur_ch_q;
    tag_t                cur_tag_q;
    logic                pend_valid_q;
    logic [CH_W-1:0]     pend_ch_q;
    tag_t                pend_tag_q;
    logic                req_latched_q;
    logic                req_issued_q;
    logic [CH_W-1:0]     req_ch_q;
    logic                ack_q;
    logic                req_done_q;
    logic [ADC_BITS-1:0] req_data_q;
    logic                smp_valid_q;
    logic [CH_W-1:0]     smp_ch_q;
    logic [ADC_BITS-1:0] smp_data_q;

    adc_spi_frame #(
        .CLK_DIV (CLK_DIV)
    ) u_frame (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .iSTART (start_d),
        .iADDR  (addr_d),
        .iDOUT  (iDOUT),
        .oDONE  (w_frm_done),
        .oDATA  (w_frm_data),
        .oBUSY  (w_busy),
        .oCS_n  (oCS_n),
        .oSCLK  (oSCLK),
        .oDIN   (oDIN)
    );

    assign w_scan_ch  = next_scan_ch(iCH_MASK, ptr_q);
    assign w_req_done = w_frm_done && pend_valid_q && (pend_tag_q == TAG_REQ);

    // Dummy frame re-addresses the pending request channel purely to clock out its result.
    always_comb begin
        start_d = 1'b0;
        addr_d  = '0;
        tag_d   = TAG_SCAN;
        ptr_d   = ptr_q;
        if (!w_busy) begin
            if (req_latched_q) begin
                start_d = 1'b1;
                addr_d  = req_ch_q;
                tag_d   = TAG_REQ;
            end else if (iEN && (|iCH_MASK)) begin
                start_d = 1'b1;
                addr_d  = w_scan_ch;
                ptr_d   = w_scan_ch;
            end else if (pend_valid_q && (pend_tag_q == TAG_REQ)) begin
                start_d = 1'b1;
                addr_d  = pend_ch_q;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            ptr_q         <= 3'(NUM_CH - 1);
            cur_ch_q      <= '0;
            cur_tag_q     <= TAG_SCAN;
            pend_valid_q  <= 1'b0;
            pend_ch_q     <= '0;
            pend_tag_q    <= TAG_SCAN;
            req_latched_q <= 1'b0;
            req_issued_q  <= 1'b0;
            req_ch_q      <= '0;
            ack_q         <= 1'b0;
            req_done_q    <= 1'b0;
            req_data_q    <= '0;
            smp_valid_q   <= 1'b0;
            smp_ch_q      <= '0;
            smp_data_q    <= '0;
        end else begin
            ack_q       <= 1'b0;
            req_done_q  <= 1'b0;
            smp_valid_q <= 1'b0;

            if (!w_busy) begin
                if (start_d) begin
                    cur_ch_q  <= addr_d;
                    cur_tag_q <= tag_d;
                    ptr_q     <= ptr_d;
                end else begin
                    pend_valid_q <= 1'b0;
                end
            end

            if (w_frm_done) begin
                if (pend_valid_q) begin
                    smp_valid_q <= 1'b1;
                    smp_ch_q    <= pend_ch_q;
                    smp_data_q  <= w_frm_data;
                end
                if (w_req_done) begin
                    req_done_q <= 1'b1;
                    req_data_q <= w_frm_data;
                end
                pend_valid_q <= 1'b1;
                pend_ch_q    <= cur_ch_q;
                pend_tag_q   <= cur_tag_q;
            end

            if (start_d && (tag_d == TAG_REQ)) begin
                req_latched_q <= 1'b0;
                req_issued_q  <= 1'b1;
            end else if (!req_latched_q && !req_issued_q && iREQ) begin
                req_latched_q <= 1'b1;
                req_ch_q      <= iREQ_CH;
                ack_q         <= 1'b1;
            end
            if (w_req_done)
                req_issued_q <= 1'b0;
        end
    end

    assign oREQ_ACK   = ack_q;
    assign oREQ_DONE  = req_done_q;
    assign oREQ_DATA  = req_data_q;
    assign oSMP_VALID = smp_valid_q;
    assign oSMP_CH    = smp_ch_q;
    assign oSMP_DATA  = smp_data_q;
    assign oBUSY      = w_busy;

endmodule
`default_nettype wire
